// File: rtl/rv32i_pkg.sv
// Shared encodings for the multi-cycle RV32I core: FSM states, opcodes and
// the select/control codes the controller drives into the datapath.
package rv32i_pkg;

  typedef enum logic [3:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_J,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    SRC_A_PC    = 2'd0,
    SRC_A_OLDPC = 2'd1,
    SRC_A_RS1   = 2'd2
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'd0,
    RES_MDR    = 2'd1,
    RES_ALU    = 2'd2,
    RES_IMM    = 2'd3
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_sel_t;

  typedef enum logic {
    ADR_PC     = 1'b0,
    ADR_ALUOUT = 1'b1
  } adr_src_t;

  // What the ALU decoder needs to know about the current state.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_ARITH  = 2'd1,
    CLS_BRANCH = 2'd2
  } alu_class_t;

  // Immediate format is purely a function of the opcode; unknown opcodes map to I.
  function automatic imm_sel_t imm_sel_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

  // funct3 values 010 and 011 are not branches in RV32I.
  function automatic logic is_branch_f3(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select: plain add outside execute/branch states,
// funct3/funct7 decode for arithmetic, comparison choice for branches.
module alu_decoder
  import rv32i_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_ctrl_t   alu_control
);

  logic is_rtype;
  logic unused_funct7;

  assign is_rtype      = (opcode == OP_REG);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLS_ARITH: begin
        case (funct3)
          3'b000:  alu_control = (is_rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        // Equality via xor, signed/unsigned order via slt/sltu; alu_zero then decides.
        case (funct3[2:1])
          2'b00:   alu_control = ALU_XOR;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM of the multi-cycle RV32I core. Outputs are decodes of the
// state register, with only the handshake- and branch-qualified strobes depending on inputs.
module multicycle_controller
  import rv32i_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] result_src,
  output logic [2:0] imm_sel,
  output logic       instr_retired,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  alu_class_t alu_class;
  alu_ctrl_t  alu_ctrl;
  logic       branch_taken;

  // NOTE: state flops use non-blocking assignments so every always_ff reads
  // the pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // NOTE: every variable written below gets a default first, otherwise an
  // unlisted case path would hold its old value and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_REG:            state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = is_branch_f3(funct3) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_J;
      S_JALR_J:   state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_BOOT;
    endcase
  end

  always_comb begin
    case (state_q)
      S_EXEC_R, S_EXEC_I: alu_class = CLS_ARITH;
      S_BRANCH:           alu_class = CLS_BRANCH;
      default:            alu_class = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (alu_ctrl)
  );

  // beq/bge/bgeu take on a zero compare result, bne/blt/bltu on non-zero.
  assign branch_taken = (alu_zero == ~(funct3[2] ^ funct3[0]));

  assign alu_control   = alu_ctrl;
  assign imm_sel       = imm_sel_of(opcode);
  assign illegal_instr = (state_q == S_TRAP);

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = ADR_PC;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALUOUT;
    instr_retired = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = ADR_PC;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR, S_EXEC_I, S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = ADR_ALUOUT;
      end
      S_MEMWB: begin
        result_src    = RES_MDR;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        mem_write     = 1'b1;
        adr_src       = ADR_ALUOUT;
        instr_retired = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALUOUT;
        pc_write      = branch_taken;
        instr_retired = 1'b1;
      end
      // Jump target comes from ALUOut while the ALU forms the link value OldPC+4.
      S_JAL, S_JALR_J: begin
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
      end
      S_LUI: begin
        result_src    = RES_IMM;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
